// File: rtl/sram_mm_arbiter_pkg.sv
// Shared types and constants for the SRAM Avalon-MM arbiter.
package sram_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RD_WAIT,
        S_RD_DATA
    } ArbState;

    localparam int READ_LATENCY = 2;

    function automatic int port_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sram_mm_arbiter_if.sv
// Host-side and controller-side Avalon-MM bundle for the arbiter.
interface sram_mm_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16
);
    logic [NUM_PORTS*ADDR_W-1:0] up_address;
    logic [NUM_PORTS-1:0]        up_read;
    logic [NUM_PORTS-1:0]        up_write;
    logic [NUM_PORTS*DATA_W-1:0] up_writedata;
    logic [NUM_PORTS-1:0]        up_waitrequest;
    logic [NUM_PORTS-1:0]        up_readdatavalid;
    logic [DATA_W-1:0]           up_readdata;
    logic [ADDR_W-1:0]           ctl_address;
    logic                        ctl_read;
    logic                        ctl_write;
    logic [DATA_W-1:0]           ctl_writedata;
    logic [DATA_W-1:0]           ctl_readdata;

    modport slave (
        input  up_address, up_read, up_write,
        input  up_writedata, ctl_readdata,
        output up_waitrequest, up_readdatavalid,
        output up_readdata, ctl_address, ctl_read,
        output ctl_write, ctl_writedata
    );

    modport master (
        output up_address, up_read, up_write,
        output up_writedata, ctl_readdata,
        input  up_waitrequest, up_readdatavalid,
        input  up_readdata, ctl_address, ctl_read,
        input  ctl_write, ctl_writedata
    );
endinterface

// File: rtl/sram_mm_arbiter_rr_picker.sv
// Round-robin picker: first requester after last_grant, wrapping.
module sram_rr_picker
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int PW        = port_idx_w(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] i_req,
    input  logic [PW-1:0]        i_last_grant,
    output logic                 o_grant_valid,
    output logic [PW-1:0]        o_grant
);
    logic [PW-1:0] w_idx;

    // Scan farthest-first so the nearest requester is the last write.
    always_comb begin
        o_grant_valid = 1'b0;
        o_grant       = '0;
        w_idx         = '0;
        for (int k = NUM_PORTS; k >= 1; k--) begin
            w_idx = PW'((int'(i_last_grant) + k) % NUM_PORTS);
            if (i_req[w_idx]) begin
                o_grant_valid = 1'b1;
                o_grant       = w_idx;
            end
        end
    end
endmodule

// File: rtl/sram_mm_arbiter.sv
// Round-robin arbiter sharing one SRAM controller between hosts.
// Define SRAM_ARB_PORT0_PRIO_EN to give port 0 strict priority.
module sram_mm_arbiter
    import sram_arb_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16
) (
    input logic         clk,
    input logic         reset_n,
    sram_mm_arbiter_if.slave bus
);
    localparam int PW = port_idx_w(NUM_PORTS);

    ArbState       r_state;
    logic [PW-1:0] r_last_grant;
    logic [PW-1:0] r_rd_owner;

    logic [NUM_PORTS-1:0] w_req;
    logic [NUM_PORTS-1:0] w_pick_req;
    logic                 w_pick_valid;
    logic [PW-1:0]        w_pick;
    logic                 w_grant_valid;
    logic [PW-1:0]        w_grant;
    logic                 w_upd_last;
    logic                 w_go;
    logic                 w_is_rd;

    assign w_req = bus.up_read | bus.up_write;

`ifdef SRAM_ARB_PORT0_PRIO_EN
    assign w_pick_req    = w_req & ~NUM_PORTS'(1);
    assign w_grant_valid = w_req[0] | w_pick_valid;
    assign w_grant       = w_req[0] ? '0 : w_pick;
    assign w_upd_last    = ~w_req[0];
`else
    assign w_pick_req    = w_req;
    assign w_grant_valid = w_pick_valid;
    assign w_grant       = w_pick;
    assign w_upd_last    = 1'b1;
`endif

    sram_rr_picker #(
        .NUM_PORTS (NUM_PORTS),
        .PW        (PW)
    ) u_picker (
        .i_req         (w_pick_req),
        .i_last_grant  (r_last_grant),
        .o_grant_valid (w_pick_valid),
        .o_grant       (w_pick)
    );

    // Gate with reset_n so outputs are quiet while reset is held.
    assign w_go    = reset_n & (r_state == S_IDLE) & w_grant_valid;
    assign w_is_rd = bus.up_read[w_grant];

    always_comb begin
        bus.ctl_address    = '0;
        bus.ctl_writedata  = '0;
        bus.ctl_read       = 1'b0;
        bus.ctl_write      = 1'b0;
        bus.up_waitrequest = '1;
        if (w_go) begin
            bus.ctl_address   =
                bus.up_address[int'(w_grant)*ADDR_W +: ADDR_W];
            bus.ctl_writedata =
                bus.up_writedata[int'(w_grant)*DATA_W +: DATA_W];
            bus.ctl_read      = w_is_rd;
            bus.ctl_write     = ~w_is_rd & bus.up_write[w_grant];
            bus.up_waitrequest[w_grant] = 1'b0;
        end
    end

    always_comb begin
        bus.up_readdatavalid = '0;
        if (r_state == S_RD_DATA)
            bus.up_readdatavalid[r_rd_owner] = 1'b1;
    end

    assign bus.up_readdata = bus.ctl_readdata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_last_grant <= PW'(NUM_PORTS - 1);
            r_rd_owner   <= '0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        if (w_upd_last)
                            r_last_grant <= w_grant;
                        if (w_is_rd) begin
                            r_rd_owner <= w_grant;
                            r_state    <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: r_state <= S_RD_DATA;
                S_RD_DATA: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_mm_arbiter.sv
// Directed scoreboard bench for sram_mm_arbiter with a controller model.
module tb_sram_mm_arbiter;
    import sram_arb_pkg::*;

`ifdef SRAM_ARB_PORT0_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic clk;
    logic reset_n;
    int   vectors;
    int   miscompares;
    int   exp_port[$];
    logic [15:0] exp_data[$];
    logic [19:0] r_rd_addr;

    sram_mm_arbiter_if #(.NUM_PORTS(2), .ADDR_W(20), .DATA_W(16)) bus();

    sram_mm_arbiter #(
        .NUM_PORTS (2),
        .ADDR_W    (20),
        .DATA_W    (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [19:0] a);
        return (a == 20'h12345) ? 16'hA5A5 : (a[15:0] ^ 16'h5A5A);
    endfunction

    always @(posedge clk or negedge reset_n)
        if (!reset_n)
            r_rd_addr <= '0;
        else if (bus.ctl_read)
            r_rd_addr <= bus.ctl_address;

    assign bus.ctl_readdata = model(r_rd_addr);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] rd, input logic [1:0] wr);
        bus.up_read  = rd;
        bus.up_write = wr;
    endtask

    always @(negedge clk) begin
        if (reset_n && bus.up_readdatavalid != 2'b00) begin
            vectors++;
            assert (exp_port.size() != 0) else begin
                miscompares++;
                $error("FAIL rdv_unexpected observed=%b expected=00",
                       bus.up_readdatavalid);
            end
            if (exp_port.size() != 0) begin
                automatic int p = exp_port.pop_front();
                automatic logic [15:0] d = exp_data.pop_front();
                vectors++;
                assert (bus.up_readdatavalid === (2'b01 << p) &&
                        bus.up_readdata === d) else begin
                    miscompares++;
                    $error("FAIL sb_read observed=%b/%h expected=%b/%h",
                           bus.up_readdatavalid, bus.up_readdata,
                           2'b01 << p, d);
                end
            end
        end
    end

    initial begin
        int acc;
        int g;
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        bus.up_address   = {20'h00010, 20'h00000};
        bus.up_writedata = {16'hBEEF, 16'h1111};
        drive(2'b00, 2'b11);
        #3;
        chk("rst_wait", 32'(bus.up_waitrequest), 32'h3);
        chk("rst_rdv", 32'(bus.up_readdatavalid), 32'h0);
        chk("rst_ctl", {30'd0, bus.ctl_read, bus.ctl_write}, 32'h0);
        drive(2'b00, 2'b00);
        nxt();
        nxt();
        reset_n = 1'b1;

        // single write from port 1
        nxt();
        drive(2'b00, 2'b10);
        @(negedge clk);
        chk("wr1_wait", 32'(bus.up_waitrequest), 32'h1);
        chk("wr1_ctl_write", 32'(bus.ctl_write), 32'h1);
        chk("wr1_addr", 32'(bus.ctl_address), 32'h00010);
        chk("wr1_data", 32'(bus.ctl_writedata), 32'hBEEF);
        chk("wr1_state", 32'(dut.r_state), 32'(S_IDLE));

        // continuous writes from both ports
        bus.up_address = {20'h00200, 20'h00100};
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            nxt();
            drive(2'b00, 2'b11);
            @(negedge clk);
            g = PRIO ? 0 : (i % 2);
            chk("rr_wait", 32'(bus.up_waitrequest),
                (g == 0) ? 32'h2 : 32'h1);
            chk("rr_addr", 32'(bus.ctl_address),
                (g == 0) ? 32'h00100 : 32'h00200);
            if (bus.ctl_write && bus.up_waitrequest != 2'b11)
                acc++;
        end
        chk("rr_count", 32'(acc), 32'd8);

        // port 0 read with fixed controller latency
        nxt();
        bus.up_address = {20'h00010, 20'h12345};
        drive(2'b01, 2'b00);
        exp_port.push_back(0);
        exp_data.push_back(16'hA5A5);
        @(negedge clk);
        chk("rd_issue", {30'd0, bus.ctl_read, bus.ctl_write}, 32'h2);
        chk("rd_wait_t", 32'(bus.up_waitrequest), 32'h2);
        chk("rd_addr", 32'(bus.ctl_address), 32'h12345);
        nxt();
        drive(2'b00, 2'b10);
        for (int k = 1; k < READ_LATENCY; k++) begin
            @(negedge clk);
            chk("rd_hold_wait", 32'(bus.up_waitrequest), 32'h3);
            chk("rd_hold_ctl", {30'd0, bus.ctl_read, bus.ctl_write}, 32'h0);
            chk("rd_hold_rdv", 32'(bus.up_readdatavalid), 32'h0);
            nxt();
        end
        @(negedge clk);
        chk("rd_data_wait", 32'(bus.up_waitrequest), 32'h3);
        chk("rd_data_rdv", 32'(bus.up_readdatavalid), 32'h1);
        chk("rd_data_val", 32'(bus.up_readdata), 32'hA5A5);
        nxt();
        @(negedge clk);
        chk("rd_next_grant", 32'(bus.up_waitrequest), 32'h1);

        // make port 0 the last grantee
        nxt();
        drive(2'b00, 2'b01);
        @(negedge clk);
        chk("lg0_wait", 32'(bus.up_waitrequest), 32'h2);

        // port 0 read and port 1 write contend
        nxt();
        bus.up_address = {20'h00010, 20'h00777};
        drive(2'b01, 2'b10);
        exp_port.push_back(0);
        exp_data.push_back(model(20'h00777));
        @(negedge clk);
`ifdef SRAM_ARB_PORT0_PRIO_EN
        chk("mix_t_wait", 32'(bus.up_waitrequest), 32'h2);
        chk("mix_t_rd", 32'(bus.ctl_read), 32'h1);
        nxt();
        drive(2'b00, 2'b10);
        @(negedge clk);
        chk("mix_t1_wait", 32'(bus.up_waitrequest), 32'h3);
        nxt();
        @(negedge clk);
        chk("mix_t2_rdv", 32'(bus.up_readdatavalid), 32'h1);
        nxt();
        @(negedge clk);
        chk("mix_t3_wait", 32'(bus.up_waitrequest), 32'h1);
`else
        chk("mix_t_wait", 32'(bus.up_waitrequest), 32'h1);
        chk("mix_t_wr", 32'(bus.ctl_write), 32'h1);
        nxt();
        drive(2'b01, 2'b00);
        @(negedge clk);
        chk("mix_t1_wait", 32'(bus.up_waitrequest), 32'h2);
        chk("mix_t1_rd", 32'(bus.ctl_read), 32'h1);
        nxt();
        drive(2'b00, 2'b00);
        @(negedge clk);
        chk("mix_t2_rdv", 32'(bus.up_readdatavalid), 32'h0);
        nxt();
        @(negedge clk);
        chk("mix_t3_rdv", 32'(bus.up_readdatavalid), 32'h1);
        chk("mix_t3_val", 32'(bus.up_readdata), 32'(model(20'h00777)));
`endif

        // asynchronous reset in the middle of a read
        nxt();
        drive(2'b01, 2'b00);
        @(negedge clk);
        chk("rr_rd_issue", 32'(bus.ctl_read), 32'h1);
        @(posedge clk);
        #2;
        drive(2'b11, 2'b00);
        reset_n = 1'b0;
        #1;
        chk("arst_wait", 32'(bus.up_waitrequest), 32'h3);
        chk("arst_rdv", 32'(bus.up_readdatavalid), 32'h0);
        chk("arst_ctl", {30'd0, bus.ctl_read, bus.ctl_write}, 32'h0);
        chk("arst_state", 32'(dut.r_state), 32'(S_IDLE));
        nxt();
        nxt();
        nxt();
        reset_n = 1'b1;
        drive(2'b00, 2'b11);
        @(negedge clk);
        chk("arst_first", 32'(bus.up_waitrequest), 32'h2);
        for (int i = 0; i < 3; i++) begin
            nxt();
            @(negedge clk);
            chk("arst_no_rdv", 32'(bus.up_readdatavalid), 32'h0);
        end

`ifdef SRAM_ARB_PORT0_PRIO_EN
        for (int i = 0; i < 6; i++) begin
            nxt();
            drive(2'b00, 2'b11);
            @(negedge clk);
            chk("prio_wait", 32'(bus.up_waitrequest), 32'h2);
        end
`endif

        nxt();
        drive(2'b00, 2'b00);
        nxt();
        chk("sb_empty", 32'(exp_port.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end
endmodule
